// File: rtl/vga_pattern_engine_if.sv
// Pattern-engine bus: mode request in, VGA connector pins and frame status out.
// The engine side uses the master modport; a board top or bench uses slave.
interface vga_pattern_engine_if #(
    parameter int COLOR_BITS = 3
);
    logic [2:0]            i_mode;
    logic                  o_vga_hsync;
    logic                  o_vga_vsync;
    logic [COLOR_BITS-1:0] o_vga_r;
    logic [COLOR_BITS-1:0] o_vga_g;
    logic [COLOR_BITS-1:0] o_vga_b;
    logic                  o_frame_start;
    logic [2:0]            o_active_mode;
    logic [7:0]            o_frame_count;

    modport master (
        input  i_mode,
        output o_vga_hsync, o_vga_vsync, o_vga_r, o_vga_g, o_vga_b,
               o_frame_start, o_active_mode, o_frame_count
    );

    modport slave (
        output i_mode,
        input  o_vga_hsync, o_vga_vsync, o_vga_r, o_vga_g, o_vga_b,
               o_frame_start, o_active_mode, o_frame_count
    );
endinterface

// File: rtl/vga_pattern_engine.sv
// VGA test-pattern source: H/V timing counters, eight static/animated patterns,
// frame-synchronous mode switching; syncs and colour leave through one register stage.
module vga_pattern_engine #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int COLOR_BITS  = 3,
    parameter int BOX_SIZE    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    vga_pattern_engine_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int RAMP_W  = COLOR_BITS + 5;
    // Counters are at least RAMP_W wide so the grey-ramp slice always exists.
    localparam int H_W     = ($clog2(H_TOTAL) > RAMP_W) ? $clog2(H_TOTAL) : RAMP_W;
    localparam int V_W     = ($clog2(V_TOTAL) > RAMP_W) ? $clog2(V_TOTAL) : RAMP_W;
    localparam int BAR_W   = H_VISIBLE / 8;
    localparam int BC_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [H_W-1:0]  H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]  H_VIS    = H_W'(H_VISIBLE);
    localparam logic [H_W-1:0]  H_EDGE   = H_W'(H_VISIBLE - 1);
    localparam logic [H_W-1:0]  HS_START = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0]  HS_END   = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [H_W-1:0]  BOX_H    = H_W'(BOX_SIZE);
    localparam logic [H_W-1:0]  BX_MAX   = H_W'(H_VISIBLE - BOX_SIZE);
    localparam logic [V_W-1:0]  V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]  V_VIS    = V_W'(V_VISIBLE);
    localparam logic [V_W-1:0]  V_EDGE   = V_W'(V_VISIBLE - 1);
    localparam logic [V_W-1:0]  VS_START = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0]  VS_END   = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [V_W-1:0]  BOX_V    = V_W'(BOX_SIZE);
    localparam logic [V_W-1:0]  BY_MAX   = V_W'(V_VISIBLE - BOX_SIZE);
    localparam logic [BC_W-1:0] BAR_LAST = BC_W'(BAR_W - 1);
    localparam logic [3:0]      BAR_NONE = 4'd8;

    function automatic logic [COLOR_BITS-1:0] level(input logic on);
        return {COLOR_BITS{on}};
    endfunction

    logic [H_W-1:0]        hpos_q, hpos_d, bx_q, bx_d;
    logic [V_W-1:0]        vpos_q, vpos_d, by_q, by_d;
    logic [BC_W-1:0]       bar_cnt_q, bar_cnt_d;
    logic [3:0]            bar_idx_q, bar_idx_d;
    logic                  dx_q, dx_d, dy_q, dy_d;
    logic [2:0]            active_mode_q, active_mode_d;
    logic [7:0]            frame_count_q, frame_count_d;
    logic                  hsync_q, hsync_d, vsync_q, vsync_d, frame_start_q, frame_start_d;
    logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic                  frame_end, visible, in_box, border;

    // Raster counters; the bar sub-counter walks bar boundaries without a divider.
    always_comb begin
        hpos_d    = hpos_q + 1'b1;
        vpos_d    = vpos_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        frame_end = (hpos_q == H_LAST) && (vpos_q == V_LAST);
        if (hpos_q == H_LAST) begin
            hpos_d    = '0;
            vpos_d    = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if ((hpos_q < H_VIS) && (bar_idx_q != BAR_NONE)) begin
            if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 4'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
            end
        end
    end

    // Per-frame state changes only on the last counter cycle, so a frame never mixes modes.
    always_comb begin
        active_mode_d = active_mode_q;
        frame_count_d = frame_count_q;
        bx_d          = bx_q;
        by_d          = by_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        if (frame_end) begin
            active_mode_d = vga.i_mode;
            frame_count_d = frame_count_q + 8'd1;
            bx_d          = dx_q ? bx_q + 1'b1 : bx_q - 1'b1;
            by_d          = dy_q ? by_q + 1'b1 : by_q - 1'b1;
            if (bx_d == BX_MAX)  dx_d = 1'b0;
            else if (bx_d == '0) dx_d = 1'b1;
            if (by_d == BY_MAX)  dy_d = 1'b0;
            else if (by_d == '0) dy_d = 1'b1;
        end
    end

    always_comb begin
        visible = (hpos_q < H_VIS) && (vpos_q < V_VIS);
        in_box  = (hpos_q >= bx_q) && (hpos_q < bx_q + BOX_H) &&
                  (vpos_q >= by_q) && (vpos_q < by_q + BOX_V);
        border  = (hpos_q == '0) || (hpos_q == H_EDGE) || (vpos_q == '0) || (vpos_q == V_EDGE);
        r_d = '0;
        g_d = '0;
        b_d = '0;
        case (active_mode_q)
            3'd0: if (bar_idx_q != BAR_NONE) begin
                r_d = level(~bar_idx_q[1]);
                g_d = level(~bar_idx_q[2]);
                b_d = level(~bar_idx_q[0]);
            end
            3'd1: begin
                r_d = level(hpos_q[5] ^ vpos_q[5]);
                g_d = r_d;
                b_d = r_d;
            end
            3'd2: begin
                r_d = hpos_q[RAMP_W-1:5];
                g_d = r_d;
                b_d = r_d;
            end
            3'd3: begin
                r_d = vpos_q[RAMP_W-1:5];
                g_d = r_d;
                b_d = r_d;
            end
            3'd4: begin
                r_d = level(in_box);
                g_d = r_d;
                b_d = r_d;
            end
            3'd5: begin
                r_d = level(1'b1);
                g_d = r_d;
                b_d = r_d;
            end
            3'd6: begin
                r_d = level(border);
                g_d = r_d;
                b_d = level(1'b1);
            end
            default: begin
                r_d = level(frame_count_q[7]);
                g_d = level(frame_count_q[6]);
                b_d = level(frame_count_q[5]);
            end
        endcase
        if (!visible) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
        hsync_d       = ((hpos_q >= HS_START) && (hpos_q < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d       = ((vpos_q >= VS_START) && (vpos_q < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        frame_start_d = (hpos_q == '0) && (vpos_q == '0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
            active_mode_q <= '0;
            frame_count_q <= '0;
            bx_q          <= '0;
            by_q          <= '0;
            dx_q          <= 1'b1;
            dy_q          <= 1'b1;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_idx_q     <= bar_idx_d;
            active_mode_q <= active_mode_d;
            frame_count_q <= frame_count_d;
            bx_q          <= bx_d;
            by_q          <= by_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.o_vga_hsync   = hsync_q;
    assign vga.o_vga_vsync   = vsync_q;
    assign vga.o_vga_r       = r_q;
    assign vga.o_vga_g       = g_q;
    assign vga.o_vga_b       = b_q;
    assign vga.o_frame_start = frame_start_q;
    assign vga.o_active_mode = active_mode_q;
    assign vga.o_frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_pattern_engine.sv
// Directed bench for vga_pattern_engine on a shrunken raster (60x24 clocks per frame)
// so that many frames, including a full box bounce, fit in a short run.
module tb_vga_pattern_engine;
    localparam int HV = 50, HF = 2, HS = 4, HB = 4;
    localparam int VV = 20, VF = 1, VS = 2, VB = 1;
    localparam int CB = 3, BOX = 16;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int BX_MAX = HV - BOX;
    localparam int BY_MAX = VV - BOX;

    typedef struct {
        int mode; int h; int v;
        int r; int g; int b; int hs; int vs; int fs;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cur_h, cur_v, frame_no, disp_mode, sampled_mode;

    vga_pattern_engine_if #(.COLOR_BITS(CB)) vga();

    vga_pattern_engine #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1'b0), .COLOR_BITS(CB), .BOX_SIZE(BOX)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .vga    (vga)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input int er, input int eg, input int eb);
        chk({tag, " r"}, int'(vga.o_vga_r), er);
        chk({tag, " g"}, int'(vga.o_vga_g), eg);
        chk({tag, " b"}, int'(vga.o_vga_b), eb);
    endtask

    // One clock; the model tracks which counter position the outputs now show.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cur_h == HT - 1) begin
            cur_h = 0;
            if (cur_v == VT - 1) begin
                cur_v     = 0;
                frame_no  = frame_no + 1;
                disp_mode = sampled_mode;
            end else begin
                cur_v = cur_v + 1;
            end
        end else begin
            cur_h = cur_h + 1;
        end
        if (cur_h == HT - 1 && cur_v == VT - 1) sampled_mode = int'(vga.i_mode);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cur_h = 0; cur_v = 0; frame_no = 0; disp_mode = 0; sampled_mode = 0;
    endtask

    task automatic goto_px(input int h, input int v, input int mode, input int frame);
        int n;
        n = 0;
        while (!(cur_h == h && cur_v == v && disp_mode == mode && (frame < 0 || frame_no == frame))) begin
            if (n == 3 * FRAME) begin
                n_cmp++;
                n_fail++;
                $display("FAIL goto (%0d,%0d) mode %0d: not reached within %0d cycles", h, v, mode, n);
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic box_px(input int h, input int v, input int f, input int white);
        goto_px(h, v, 4, f);
        chk_pix($sformatf("box f%0d (%0d,%0d)", f, h, v), white * 7, white * 7, white * 7);
    endtask

    initial begin
        vec_t vecs[$];
        int   hs_low, vs_low, fs_cnt, bx, by, dx, dy, fc;
        string tag;

        vecs.push_back('{0,  0,  0, 7, 7, 7, 1, 1, 1});
        vecs.push_back('{0,  5,  0, 7, 7, 7, 1, 1, 0});
        vecs.push_back('{0,  6,  0, 7, 7, 0, 1, 1, 0});
        vecs.push_back('{0, 12,  2, 0, 7, 7, 1, 1, 0});
        vecs.push_back('{0, 20,  5, 0, 7, 0, 1, 1, 0});
        vecs.push_back('{0, 24,  5, 7, 0, 7, 1, 1, 0});
        vecs.push_back('{0, 30,  5, 7, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 36,  5, 0, 0, 7, 1, 1, 0});
        vecs.push_back('{0, 47,  5, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 48,  5, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 51,  5, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 52,  5, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 55,  5, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 56,  5, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 10, 19, 7, 7, 0, 1, 1, 0});
        vecs.push_back('{0, 10, 20, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 10, 21, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 59, 22, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 10, 23, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{1, 31,  2, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{1, 32,  2, 7, 7, 7, 1, 1, 0});
        vecs.push_back('{1, 49,  3, 7, 7, 7, 1, 1, 0});
        vecs.push_back('{1, 50,  3, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{2, 31,  1, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{2, 32,  1, 1, 1, 1, 1, 1, 0});
        vecs.push_back('{2, 49,  1, 1, 1, 1, 1, 1, 0});
        vecs.push_back('{3, 40, 19, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{5,  0,  0, 7, 7, 7, 1, 1, 1});
        vecs.push_back('{5, 25, 10, 7, 7, 7, 1, 1, 0});
        vecs.push_back('{5, 10, 20, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{6, 10,  0, 7, 7, 7, 1, 1, 0});
        vecs.push_back('{6,  0,  5, 7, 7, 7, 1, 1, 0});
        vecs.push_back('{6,  1,  5, 0, 0, 7, 1, 1, 0});
        vecs.push_back('{6, 48, 18, 0, 0, 7, 1, 1, 0});
        vecs.push_back('{6, 49,  5, 7, 7, 7, 1, 1, 0});
        vecs.push_back('{6, 10, 19, 7, 7, 7, 1, 1, 0});

        vga.i_mode = 3'd0;
        cur_h = 0; cur_v = 0; frame_no = 0; disp_mode = 0; sampled_mode = 0;

        // Reset held for three cycles, then the first pixel of frame 0.
        repeat (3) @(posedge clk);
        #1;
        chk("reset hsync", int'(vga.o_vga_hsync), 1);
        chk("reset vsync", int'(vga.o_vga_vsync), 1);
        chk_pix("reset", 0, 0, 0);
        chk("reset frame_start", int'(vga.o_frame_start), 0);
        chk("reset active_mode", int'(vga.o_active_mode), 0);
        chk("reset frame_count", int'(vga.o_frame_count), 0);
        release_reset();
        chk("first frame_start", int'(vga.o_frame_start), 1);
        chk("first hsync", int'(vga.o_vga_hsync), 1);
        chk("first vsync", int'(vga.o_vga_vsync), 1);
        chk_pix("first pixel", 7, 7, 7);

        // Sync pulse totals over one whole frame.
        hs_low = 0; vs_low = 0; fs_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (vga.o_vga_hsync == 1'b0) hs_low++;
            if (vga.o_vga_vsync == 1'b0) vs_low++;
            if (vga.o_frame_start) fs_cnt++;
            tick();
        end
        chk("hsync low cycles per frame", hs_low, HS * VT);
        chk("vsync low cycles per frame", vs_low, VS * HT);
        chk("frame_start pulses per frame", fs_cnt, 1);
        chk("frame_count after one frame", int'(vga.o_frame_count), 1);

        foreach (vecs[i]) begin
            vga.i_mode = 3'(vecs[i].mode);
            goto_px(vecs[i].h, vecs[i].v, vecs[i].mode, -1);
            tag = $sformatf("m%0d (%0d,%0d)", vecs[i].mode, vecs[i].h, vecs[i].v);
            chk_pix(tag, vecs[i].r, vecs[i].g, vecs[i].b);
            chk({tag, " hsync"}, int'(vga.o_vga_hsync), vecs[i].hs);
            chk({tag, " vsync"}, int'(vga.o_vga_vsync), vecs[i].vs);
            chk({tag, " frame_start"}, int'(vga.o_frame_start), vecs[i].fs);
            chk({tag, " active_mode"}, int'(vga.o_active_mode), vecs[i].mode);
        end

        // Mode request changed mid-frame takes effect only at the next frame.
        vga.i_mode = 3'd0;
        goto_px(0, 10, 0, -1);
        vga.i_mode = 3'd2;
        goto_px(6, 15, 0, -1);
        chk_pix("midframe switch bars", 7, 7, 0);
        chk("midframe switch active_mode", int'(vga.o_active_mode), 0);
        goto_px(32, 0, 2, -1);
        chk_pix("switched ramp", 1, 1, 1);
        chk("switched active_mode", int'(vga.o_active_mode), 2);
        chk("switched frame_count", int'(vga.o_frame_count), frame_no);

        // Reset in the middle of a frame.
        goto_px(30, 10, 2, -1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset hsync", int'(vga.o_vga_hsync), 1);
        chk("midreset vsync", int'(vga.o_vga_vsync), 1);
        chk_pix("midreset", 0, 0, 0);
        chk("midreset frame_start", int'(vga.o_frame_start), 0);
        chk("midreset frame_count", int'(vga.o_frame_count), 0);
        chk("midreset active_mode", int'(vga.o_active_mode), 0);
        vga.i_mode = 3'd4;
        @(posedge clk);
        #1;
        release_reset();
        chk("post-reset frame_start", int'(vga.o_frame_start), 1);
        chk_pix("post-reset pixel", 7, 7, 7);
        chk("post-reset active_mode", int'(vga.o_active_mode), 0);

        // Bouncing box, frames 1..36 after reset: bx peaks at BX_MAX, by bounces 0..BY_MAX.
        bx = 0; by = 0; dx = 1; dy = 1;
        for (int f = 1; f <= 36; f++) begin
            bx = (dx != 0) ? bx + 1 : bx - 1;
            by = (dy != 0) ? by + 1 : by - 1;
            if (bx == BX_MAX) dx = 0; else if (bx == 0) dx = 1;
            if (by == BY_MAX) dy = 0; else if (by == 0) dy = 1;
            if (by > 0) box_px(bx, by - 1, f, 0);
            if (bx > 0) box_px(bx - 1, by, f, 0);
            box_px(bx, by, f, 1);
            box_px(bx + BOX - 1, by, f, 1);
            box_px(bx + BOX, by, f, 0);
            box_px(bx, by + BOX - 1, f, 1);
            box_px(bx, by + BOX, f, 0);
        end

        // Cycling solid colour follows frame_count[7:5].
        vga.i_mode = 3'd7;
        goto_px(10, 10, 7, -1);
        fc = frame_no % 256;
        chk("cycling frame_count", int'(vga.o_frame_count), fc);
        chk("cycling active_mode", int'(vga.o_active_mode), 7);
        chk_pix("cycling", ((fc >> 7) & 1) * 7, ((fc >> 6) & 1) * 7, ((fc >> 5) & 1) * 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
